// File: rtl/irq_ctrl_pkg.sv
// Shared widths, FSM encodings and a one-hot helper for the interrupt controller.
package irq_ctrl_pkg;
  localparam int NUM_IRQ  = 4;
  localparam int IRQ_ID_W = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IRQ_ID_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction
endpackage

// File: rtl/irq_sync.sv
// Per-line SYNC_STAGES synchroniser plus registered rising-edge detector (SYNC_STAGES >= 2).
// IRQ_LEVEL_EN: output the synchronised level instead of the edge pulse.
module irq_sync
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int W           = NUM_IRQ
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_evt
);
  logic [SYNC_STAGES-1:0][W-1:0] r_chain;
  logic [W-1:0]                  r_prev;
  logic [W-1:0]                  r_rise;
  logic [SYNC_STAGES:0]          r_arm;
  logic [W-1:0]                  w_sync;

  assign w_sync = r_chain[SYNC_STAGES-1];

  // r_arm blocks the false edge seen while the chain fills after reset,
  // so a line held high through reset never registers as a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
      r_prev  <= '0;
      r_rise  <= '0;
      r_arm   <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_prev  <= w_sync;
      r_arm   <= {r_arm[SYNC_STAGES-1:0], 1'b1};
      r_rise  <= w_sync & ~r_prev & {W{r_arm[SYNC_STAGES]}};
    end
  end

`ifdef IRQ_LEVEL_EN
  assign o_evt = w_sync;
`else
  assign o_evt = r_rise;
`endif
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller front-end: sync/edge-detect, pending+mask to encoder, req/ack/eoi FSM.
// IRQ_LEVEL_EN selects level-sensitive pending (not cleared by ack); default is edge-triggered.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                int_en,
  input  logic                mask_wr,
  input  logic [NUM_IRQ-1:0]  mask_data,
  output logic [NUM_IRQ-1:0]  enc_in,
  output logic                enc_enable,
  input  logic [IRQ_ID_W-1:0] enc_out,
  input  logic                enc_valid,
  output logic                irq_req,
  output logic [IRQ_ID_W-1:0] irq_id,
  input  logic                irq_ack,
  input  logic                eoi,
  output logic [NUM_IRQ-1:0]  in_service
);
  logic [NUM_IRQ-1:0]  w_evt;
  logic [NUM_IRQ-1:0]  w_clr;
  logic                w_ack;
  logic                w_eoi;
  logic [NUM_IRQ-1:0]  r_pending;
  logic [NUM_IRQ-1:0]  r_mask;
  logic [NUM_IRQ-1:0]  r_in_service;
  logic [1:0]          r_state;
  logic [IRQ_ID_W-1:0] r_irq_id;
  logic                r_irq_req;
  logic                r_live;

  irq_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .W           (NUM_IRQ)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (irq_in),
    .o_evt   (w_evt)
  );

  assign w_ack = (r_state == ST_REQ) && irq_ack;
  assign w_eoi = (r_state == ST_SERVICE) && eoi;
  assign w_clr = w_ack ? onehot(r_irq_id) : '0;

  // r_live keeps the encoder disabled while reset is held.
  assign enc_in     = r_pending & r_mask;
  assign enc_enable = int_en && r_live && (r_state == ST_IDLE);
  assign irq_req    = r_irq_req;
  assign irq_id     = r_irq_id;
  assign in_service = r_in_service;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_live    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (mask_wr) r_mask <= mask_data;
`ifdef IRQ_LEVEL_EN
      r_pending <= w_evt;
`else
      // A new edge wins over the ack clear of the same bit.
      r_pending <= (r_pending & ~w_clr) | w_evt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_irq_req    <= 1'b0;
      r_irq_id     <= '0;
      r_in_service <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enc_enable && enc_valid) begin
            r_irq_id  <= enc_out;
            r_irq_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack) begin
            r_irq_req    <= 1'b0;
            r_in_service <= onehot(r_irq_id);
            r_state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (w_eoi) begin
            r_in_service <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] irq_in = 4'b0;
  logic       int_en = 1'b0;
  logic       mask_wr = 1'b0;
  logic [3:0] mask_data = 4'b0;
  logic [3:0] enc_in;
  logic       enc_enable;
  logic [1:0] enc_out;
  logic       enc_valid;
  logic       irq_req;
  logic [1:0] irq_id;
  logic       irq_ack = 1'b0;
  logic       eoi = 1'b0;
  logic [3:0] in_service;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .int_en     (int_en),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .enc_in     (enc_in),
    .enc_enable (enc_enable),
    .enc_out    (enc_out),
    .enc_valid  (enc_valid),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  // Highest-numbered set line wins.
  function automatic logic [1:0] prio(input logic [3:0] v);
    prio = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) prio = i[1:0];
  endfunction

  assign enc_valid = |enc_in;
  assign enc_out   = prio(enc_in);

  // Reference model: pending at edge n sees line samples from edges n-3 and n-4.
  localparam logic [1:0] M_IDLE = 2'd0, M_REQ = 2'd1, M_SVC = 2'd2;
  logic [3:0] h1, h2, h3, h4;
  int         m_ncyc;
  logic [3:0] m_pend, m_mask, m_svc, m_enc, m_rise, m_clr;
  logic [1:0] m_st, m_id;
  logic       m_req, m_en;

  assign m_enc  = m_pend & m_mask;
  assign m_en   = int_en && (m_st == M_IDLE) && (m_ncyc != 0);
  assign m_rise = (m_ncyc >= 4) ? (h3 & ~h4) : 4'b0;
  assign m_clr  = (m_st == M_REQ && irq_ack) ? (4'b0001 << m_id) : 4'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {h4, h3, h2, h1} <= 16'h0;
      m_ncyc <= 0;
      m_pend <= 4'b0; m_mask <= 4'b0; m_svc <= 4'b0;
      m_st <= M_IDLE; m_id <= 2'd0; m_req <= 1'b0;
    end else begin
      m_ncyc <= (m_ncyc < 100) ? m_ncyc + 1 : m_ncyc;
      {h4, h3, h2, h1} <= {h3, h2, h1, irq_in};
      m_pend <= (m_pend & ~m_clr) | m_rise;
      if (mask_wr) m_mask <= mask_data;
      case (m_st)
        M_IDLE: if (m_en && m_enc != 4'b0) begin
          m_id <= prio(m_enc); m_req <= 1'b1; m_st <= M_REQ;
        end
        M_REQ: if (irq_ack) begin
          m_req <= 1'b0; m_svc <= 4'b0001 << m_id; m_st <= M_SVC;
        end
        M_SVC: if (eoi) begin
          m_svc <= 4'b0; m_st <= M_IDLE;
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_checks = n_checks + 1;
      if ({irq_req, irq_id, in_service, enc_in, enc_enable} !== {m_req, m_id, m_svc, m_enc, m_en}) begin
        n_fail = n_fail + 1;
        $display("FAIL monitor t=%0t got req=%b id=%0d svc=%b enc=%b en=%b required req=%b id=%0d svc=%b enc=%b en=%b",
                 $time, irq_req, irq_id, in_service, enc_in, enc_enable, m_req, m_id, m_svc, m_enc, m_en);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; cyc(); eoi = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; int_en = 1'b1;
    cyc(2);
    n_checks++; if ({irq_req, irq_id, in_service} !== 7'b0) begin n_fail++;
      $display("FAIL reset_outs got req=%b id=%b svc=%b required 0", irq_req, irq_id, in_service); end
    n_checks++; if ({enc_in, enc_enable} !== 5'b0) begin n_fail++;
      $display("FAIL reset_enc got enc=%b en=%b required 0", enc_in, enc_enable); end
    rst_n = 1'b1;
    cyc(6);
    mask_wr = 1'b1; mask_data = 4'b1111; cyc(); mask_wr = 1'b0;
    n_checks++; if (enc_enable !== 1'b1) begin n_fail++;
      $display("FAIL post_reset_en got %b required 1", enc_enable); end
  endtask

  task automatic test_basic();
    irq_in[2] = 1'b1;
    cyc(4);
    n_checks++; if (irq_req !== 1'b0) begin n_fail++;
      $display("FAIL basic_early got req=%b required 0", irq_req); end
    cyc();
    n_checks++; if ({irq_req, irq_id} !== 3'b110) begin n_fail++;
      $display("FAIL basic_req got req=%b id=%0d required req=1 id=2", irq_req, irq_id); end
    pulse_ack();
    n_checks++; if ({irq_req, in_service, enc_in[2]} !== 6'b0_0100_0) begin n_fail++;
      $display("FAIL basic_ack got req=%b svc=%b pend2=%b required 0 0100 0", irq_req, in_service, enc_in[2]); end
    pulse_eoi();
    n_checks++; if (in_service !== 4'b0) begin n_fail++;
      $display("FAIL basic_eoi got svc=%b required 0000", in_service); end
    irq_in = 4'b0; cyc(3);
  endtask

  task automatic test_back_to_back();
    irq_in = 4'b1001;
    cyc(5);
    n_checks++; if ({irq_req, irq_id} !== 3'b111) begin n_fail++;
      $display("FAIL b2b_first got req=%b id=%0d required req=1 id=3", irq_req, irq_id); end
    pulse_ack();
    n_checks++; if (in_service !== 4'b1000) begin n_fail++;
      $display("FAIL b2b_svc got %b required 1000", in_service); end
    pulse_eoi();
    n_checks++; if (irq_req !== 1'b0) begin n_fail++;
      $display("FAIL b2b_gap got req=%b required 0", irq_req); end
    cyc();
    n_checks++; if ({irq_req, irq_id} !== 3'b100) begin n_fail++;
      $display("FAIL b2b_second got req=%b id=%0d required req=1 id=0", irq_req, irq_id); end
    pulse_ack(); pulse_eoi();
    irq_in = 4'b0; cyc(3);
  endtask

  task automatic test_mask();
    mask_wr = 1'b1; mask_data = 4'b0111; cyc(); mask_wr = 1'b0;
    irq_in[3] = 1'b1;
    cyc(8);
    n_checks++; if ({irq_req, enc_in} !== 5'b0) begin n_fail++;
      $display("FAIL mask_block got req=%b enc=%b required 0 0000", irq_req, enc_in); end
    mask_wr = 1'b1; mask_data = 4'b1111; cyc(); mask_wr = 1'b0;
    n_checks++; if ({irq_req, enc_in} !== 5'b0_1000) begin n_fail++;
      $display("FAIL mask_open got req=%b enc=%b required 0 1000", irq_req, enc_in); end
    cyc();
    n_checks++; if ({irq_req, irq_id} !== 3'b111) begin n_fail++;
      $display("FAIL mask_req got req=%b id=%0d required req=1 id=3", irq_req, irq_id); end
    pulse_ack(); pulse_eoi();
    irq_in = 4'b0; cyc(3);
  endtask

  task automatic test_set_clear();
    irq_in[1] = 1'b1;
    cyc(5);
    n_checks++; if ({irq_req, irq_id} !== 3'b101) begin n_fail++;
      $display("FAIL sc_req got req=%b id=%0d required req=1 id=1", irq_req, irq_id); end
    irq_in[1] = 1'b0; cyc();
    irq_in[1] = 1'b1; cyc(3);
    pulse_ack();
    n_checks++; if ({in_service, enc_in[1]} !== 5'b0010_1) begin n_fail++;
      $display("FAIL sc_setwins got svc=%b pend1=%b required 0010 1", in_service, enc_in[1]); end
    pulse_eoi(); cyc();
    n_checks++; if ({irq_req, irq_id} !== 3'b101) begin n_fail++;
      $display("FAIL sc_rereq got req=%b id=%0d required req=1 id=1", irq_req, irq_id); end
    pulse_ack(); pulse_eoi();
    n_checks++; if (enc_in !== 4'b0) begin n_fail++;
      $display("FAIL sc_clear got enc=%b required 0000", enc_in); end
    irq_in = 4'b0; cyc(3);
  endtask

  task automatic test_int_en();
    int_en = 1'b0; irq_in[0] = 1'b1;
    cyc(8);
    n_checks++; if ({enc_enable, irq_req, enc_in} !== 6'b0_0_0001) begin n_fail++;
      $display("FAIL inten_off got en=%b req=%b enc=%b required 0 0 0001", enc_enable, irq_req, enc_in); end
    int_en = 1'b1; cyc();
    n_checks++; if ({irq_req, irq_id} !== 3'b100) begin n_fail++;
      $display("FAIL inten_on got req=%b id=%0d required req=1 id=0", irq_req, irq_id); end
    int_en = 1'b0; cyc(3);
    n_checks++; if ({irq_req, enc_enable} !== 2'b10) begin n_fail++;
      $display("FAIL inten_hold got req=%b en=%b required 1 0", irq_req, enc_enable); end
    pulse_ack();
    n_checks++; if ({irq_req, in_service} !== 5'b0_0001) begin n_fail++;
      $display("FAIL inten_ack got req=%b svc=%b required 0 0001", irq_req, in_service); end
    pulse_eoi(); int_en = 1'b1; irq_in = 4'b0; cyc(3);
  endtask

  task automatic test_reset_mid();
    irq_in[2] = 1'b1;
    cyc(5); pulse_ack();
    n_checks++; if (in_service !== 4'b0100) begin n_fail++;
      $display("FAIL rm_svc got %b required 0100", in_service); end
    #1 rst_n = 1'b0; #1;
    n_checks++; if ({irq_req, irq_id, in_service, enc_in, enc_enable} !== 12'b0) begin n_fail++;
      $display("FAIL rm_async got req=%b id=%b svc=%b enc=%b en=%b required 0", irq_req, irq_id, in_service, enc_in, enc_enable); end
    cyc(); rst_n = 1'b1;
    cyc(3);
    mask_wr = 1'b1; mask_data = 4'b1111; cyc(); mask_wr = 1'b0;
    cyc(8);
    n_checks++; if ({irq_req, enc_in} !== 5'b0) begin n_fail++;
      $display("FAIL rm_held_line got req=%b enc=%b required 0 0000", irq_req, enc_in); end
    int_en = 1'b0; irq_in = 4'b0; cyc(2);
    irq_in[0] = 1'b1; cyc(6);
    irq_ack = 1'b1; eoi = 1'b1; cyc(); irq_ack = 1'b0; eoi = 1'b0;
    n_checks++; if ({irq_req, in_service, enc_in} !== 9'b0_0000_0001) begin n_fail++;
      $display("FAIL rm_stray got req=%b svc=%b enc=%b required 0 0000 0001", irq_req, in_service, enc_in); end
    int_en = 1'b1; cyc();
    n_checks++; if ({irq_req, irq_id} !== 3'b100) begin n_fail++;
      $display("FAIL rm_after_stray got req=%b id=%0d required req=1 id=0", irq_req, irq_id); end
    pulse_ack(); pulse_eoi(); irq_in = 4'b0; cyc(3);
  endtask

  task automatic test_random();
    int serviced = 0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      int_en    = ($urandom_range(0, 7) != 0);
      mask_wr   = ($urandom_range(0, 15) == 0);
      mask_data = 4'($urandom_range(0, 15));
      irq_ack   = ($urandom_range(0, 2) == 0);
      eoi       = ($urandom_range(0, 2) == 0);
      if (irq_req && irq_ack) serviced++;
      cyc();
    end
    irq_ack = 1'b0; eoi = 1'b0; mask_wr = 1'b0; irq_in = 4'b0;
    cyc(3);
    n_checks++; if (serviced == 0) begin n_fail++;
      $display("FAIL rand_activity got %0d serviced required >0", serviced); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_mask();
    test_set_clear();
    test_int_en();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
